// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
// The optional match counter is enabled by defining SEQ_DET_MATCH_CNT_EN.
package seq_detector_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    DETECT = 2'd2
  } state_t;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 16;
  // Widest pattern the compare helper supports; callers zero-extend into it.
  localparam int MAX_PAT_W = 64;

  function automatic logic masked_match(
    input logic [MAX_PAT_W-1:0] hist,
    input logic [MAX_PAT_W-1:0] pattern,
    input logic [7:0]           len
  );
    logic [MAX_PAT_W-1:0] mask;
    // A shift by the full width yields zero, so len == MAX_PAT_W gives an all-ones mask.
    mask = (MAX_PAT_W'(1) << len) - MAX_PAT_W'(1);
    return ((hist ^ pattern) & mask) == '0;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with synchronous clear; a clear coincident
// with an increment leaves the count at one.
module seq_match_counter
  import seq_detector_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap / non-overlap modes.
// Define SEQ_DET_MATCH_CNT_EN to build the saturating match counter.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             out,
  output logic             armed,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_cnt
);

  state_t           state_reg;
  logic [PAT_W-1:0] pat_reg;
  logic [LEN_W-1:0] len_reg;
  logic             ovl_reg;
  // Only PAT_W-1 bits need storing: the newest bit arrives on `in`.
  logic [PAT_W-2:0] hist_reg;
  logic [LEN_W-1:0] fill_reg;
  logic             out_reg;
  logic             err_reg;

  logic [PAT_W-1:0] hist_next;
  logic [LEN_W-1:0] fill_next;
  logic             match_next;
  logic             cfg_legal;

  assign hist_next  = {hist_reg, in};
  assign fill_next  = (fill_reg == LEN_W'(PAT_W)) ? fill_reg : fill_reg + LEN_W'(1);
  assign match_next = masked_match(MAX_PAT_W'(hist_next), MAX_PAT_W'(pat_reg), 8'(len_reg))
                      && (fill_next >= len_reg);
  assign cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      pat_reg   <= '0;
      len_reg   <= '0;
      ovl_reg   <= 1'b0;
      hist_reg  <= '0;
      fill_reg  <= '0;
      out_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      out_reg <= 1'b0;
      if (cfg_load) begin
        pat_reg  <= cfg_pattern;
        len_reg  <= cfg_len;
        ovl_reg  <= cfg_overlap;
        hist_reg <= '0;
        fill_reg <= '0;
        if (cfg_legal) begin
          state_reg <= FILL;
        end else begin
          state_reg <= IDLE;
          err_reg   <= 1'b1;
        end
      end else if (in_valid && (state_reg != IDLE)) begin
        hist_reg <= hist_next[PAT_W-2:0];
        if (match_next) begin
          out_reg <= 1'b1;
          if (ovl_reg) begin
            fill_reg  <= fill_next;
            state_reg <= DETECT;
          end else begin
            // Emptying the fill count keeps matched bits out of any later match.
            fill_reg  <= '0;
            state_reg <= FILL;
          end
        end else begin
          fill_reg  <= fill_next;
          state_reg <= (fill_next >= len_reg) ? DETECT : FILL;
        end
      end
    end
  end

  assign out     = out_reg;
  assign armed   = (state_reg != IDLE);
  assign cfg_err = err_reg;

`ifdef SEQ_DET_MATCH_CNT_EN
  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk  (clk),
    .rstn (rstn),
    .clr  (cnt_clr),
    .inc  (out_reg),
    .cnt  (match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: expected out bits come from hand-derived
// pulse tables, queued as stimulus is driven and compared as the DUT responds.
module tb_seq_detector_param;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 2;
`ifdef SEQ_DET_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic             in_bit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             out;
  logic             armed;
  logic             cfg_err;
  logic [CNT_W-1:0] match_cnt;

  int   n_cmp = 0;
  int   n_mis = 0;
  logic exp_q[$];
  logic obs_q[$];

  always #5 clk = ~clk;

  seq_detector_param #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in          (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .out         (out),
    .armed       (armed),
    .cfg_err     (cfg_err),
    .match_cnt   (match_cnt)
  );

  // One clock: drive, queue the expected out, then record what the DUT shows after the edge.
  task automatic step(input logic v, input logic b, input logic e);
    in_valid = v;
    in_bit   = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs_q.push_back(out);
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                        input logic v, input logic b);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_load    = 1'b1;
    step(v, b, 1'b0);
    cfg_load    = 1'b0;
    $display("cfg pattern=%h len=%0d overlap=%b armed=%b cfg_err=%b", p, l, o, armed, cfg_err);
  endtask

  // First bit of the stream is bits[n-1]; pulses uses the same ordering.
  task automatic run_stream(input string name, input logic [15:0] bits,
                            input logic [15:0] pulses, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i], pulses[n-1-i]);
    end
    $display("stream %s n=%0d bits=%b pulses=%b", name, n, bits, pulses);
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    #3;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out !== 1'b0)     begin n_mis++; $display("FAIL reset_out got=%b want=0", out); end
    n_cmp++; if (armed !== 1'b0)   begin n_mis++; $display("FAIL reset_armed got=%b want=0", armed); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_mis++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
    n_cmp++; if (match_cnt !== '0) begin n_mis++; $display("FAIL reset_cnt got=%0d want=0", match_cnt); end
    rstn = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    n_cmp++; if (armed !== 1'b0)   begin n_mis++; $display("FAIL idle_armed got=%b want=0", armed); end
    while (exp_q.size() > 0) begin
      logic e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL idle_out got=%b want=%b", o, e); end
    end
    $display("test_reset done");
  endtask

  task automatic test_overlap();
    int k = 0;
    cnt_clr = 1'b1;
    do_cfg(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (armed !== 1'b1)   begin n_mis++; $display("FAIL ovl_armed got=%b want=1", armed); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_mis++; $display("FAIL ovl_cfg_err got=%b want=0", cfg_err); end
    run_stream("1011_ovl_long", 16'b10110011011, 16'b00010000001, 11);
    step(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (match_cnt !== (CNT_ON ? 2'd2 : 2'd0)) begin
      n_mis++; $display("FAIL ovl_cnt got=%0d want=%0d", match_cnt, CNT_ON ? 2 : 0);
    end
    while (exp_q.size() > 0) begin
      logic e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL ovl_out cycle=%0d got=%b want=%b", k, o, e); end
      k++;
    end
    $display("test_overlap done");
  endtask

  task automatic test_nonoverlap();
    int k = 0;
    do_cfg(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
    run_stream("1011_ovl1", 16'b1011011, 16'b0001001, 7);
    do_cfg(8'h0B, 4'd4, 1'b0, 1'b0, 1'b0);
    run_stream("1011_ovl0", 16'b1011011, 16'b0001000, 7);
    while (exp_q.size() > 0) begin
      logic e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL nonovl_out cycle=%0d got=%b want=%b", k, o, e); end
      k++;
    end
    $display("test_nonoverlap done");
  endtask

  // The config cycle carries a valid '1' that must be discarded.
  task automatic test_run_of_ones();
    int k = 0;
    do_cfg(8'h07, 4'd3, 1'b1, 1'b1, 1'b1);
    run_stream("111_ovl1", 16'b111111, 16'b001111, 6);
    do_cfg(8'h07, 4'd3, 1'b0, 1'b1, 1'b1);
    run_stream("111_ovl0", 16'b111111, 16'b001001, 6);
    while (exp_q.size() > 0) begin
      logic e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL ones_out cycle=%0d got=%b want=%b", k, o, e); end
      k++;
    end
    $display("test_run_of_ones done");
  endtask

  task automatic test_len_bounds();
    int k = 0;
    do_cfg(8'hFE, 4'd1, 1'b1, 1'b0, 1'b0);
    run_stream("len1_bit0", 16'b0100, 16'b1011, 4);
    do_cfg(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0);
    run_stream("len8_A5", 16'b1010010110100101, 16'b0000000100000001, 16);
    while (exp_q.size() > 0) begin
      logic e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL len_out cycle=%0d got=%b want=%b", k, o, e); end
      k++;
    end
    $display("test_len_bounds done");
  endtask

  task automatic test_valid_gap();
    int k = 0;
    do_cfg(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    $display("stream valid_gap bits=1,0,(gap x3),1,1");
    while (exp_q.size() > 0) begin
      logic e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL gap_out cycle=%0d got=%b want=%b", k, o, e); end
      k++;
    end
    $display("test_valid_gap done");
  endtask

  task automatic test_cfg_err();
    int k = 0;
    pulse_reset();
    rstn = 1'b1;
    @(posedge clk); #1;
    do_cfg(8'h0B, 4'd9, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (cfg_err !== 1'b1) begin n_mis++; $display("FAIL err_len9 got=%b want=1", cfg_err); end
    n_cmp++; if (armed !== 1'b0)   begin n_mis++; $display("FAIL err_len9_armed got=%b want=0", armed); end
    run_stream("len9_ignored", 16'b101101, 16'b000000, 6);
    do_cfg(8'h0B, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (cfg_err !== 1'b1) begin n_mis++; $display("FAIL err_len0 got=%b want=1", cfg_err); end
    n_cmp++; if (armed !== 1'b0)   begin n_mis++; $display("FAIL err_len0_armed got=%b want=0", armed); end
    run_stream("len0_ignored", 16'b1011, 16'b0000, 4);
    do_cfg(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (armed !== 1'b1)   begin n_mis++; $display("FAIL err_legal_armed got=%b want=1", armed); end
    n_cmp++; if (cfg_err !== 1'b1) begin n_mis++; $display("FAIL err_sticky got=%b want=1", cfg_err); end
    run_stream("legal_after_err", 16'b1011, 16'b0001, 4);
    while (exp_q.size() > 0) begin
      logic e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL err_out cycle=%0d got=%b want=%b", k, o, e); end
      k++;
    end
    $display("test_cfg_err done");
  endtask

  task automatic test_counter();
    int k = 0;
    cnt_clr = 1'b1;
    do_cfg(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    run_stream("five_ones", 16'b11111, 16'b11111, 5);
    step(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (match_cnt !== (CNT_ON ? 2'd3 : 2'd0)) begin
      n_mis++; $display("FAIL cnt_sat got=%0d want=%0d", match_cnt, CNT_ON ? 3 : 0);
    end
    step(1'b1, 1'b1, 1'b1);
    cnt_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (match_cnt !== (CNT_ON ? 2'd1 : 2'd0)) begin
      n_mis++; $display("FAIL cnt_clr_match got=%0d want=%0d", match_cnt, CNT_ON ? 1 : 0);
    end
    cnt_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    n_cmp++; if (match_cnt !== 2'd0) begin n_mis++; $display("FAIL cnt_clr got=%0d want=0", match_cnt); end
    while (exp_q.size() > 0) begin
      logic e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL cnt_out cycle=%0d got=%b want=%b", k, o, e); end
      k++;
    end
    $display("test_counter done");
  endtask

  task automatic test_reset_mid();
    int k = 0;
    do_cfg(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
    run_stream("partial", 16'b101, 16'b000, 3);
    step(1'b1, 1'b1, 1'b1);
    pulse_reset();
    n_cmp++; if (out !== 1'b0)     begin n_mis++; $display("FAIL mid_rst_out got=%b want=0", out); end
    n_cmp++; if (armed !== 1'b0)   begin n_mis++; $display("FAIL mid_rst_armed got=%b want=0", armed); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_mis++; $display("FAIL mid_rst_err got=%b want=0", cfg_err); end
    n_cmp++; if (match_cnt !== '0) begin n_mis++; $display("FAIL mid_rst_cnt got=%0d want=0", match_cnt); end
    rstn = 1'b1;
    @(posedge clk); #1;
    run_stream("after_rst", 16'b1011011, 16'b0000000, 7);
    n_cmp++; if (armed !== 1'b0)   begin n_mis++; $display("FAIL post_rst_armed got=%b want=0", armed); end
    while (exp_q.size() > 0) begin
      logic e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL mid_out cycle=%0d got=%b want=%b", k, o, e); end
      k++;
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_run_of_ones();
    test_len_bounds();
    test_valid_gap();
    test_cfg_err();
    test_counter();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the fixed-pattern serial sequence detector.
- Detects a runtime-programmable bit pattern of length 1..PAT_W on a 1-bit qualified serial stream.
- Supports overlapping and non-overlapping match modes, and optionally counts matches (saturating).
- Sits on serial control/line-monitor paths; pattern, length and mode are loaded via a one-cycle config strobe.

Parameters:
- PAT_W, 8: maximum pattern length in bits (>=2).
- LEN_W, $clog2(PAT_W+1): width of cfg_len.
- CNT_W, 16: width of match counter.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies `in`; the bit is sampled only when high.
- in  input  1  serial data bit.
- cfg_load  input  1  one-cycle strobe; latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  input  PAT_W  pattern bits [len-1:0]; bit len-1 is received first.
- cfg_len  input  LEN_W  pattern length; legal range 1..PAT_W.
- cfg_overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_cnt.
- out  output  1  one-cycle match pulse.
- armed  output  1  high when a legal config is loaded (state != IDLE).
- cfg_err  output  1  sticky; set by a load with cfg_len==0 or cfg_len>PAT_W.
- match_cnt  output  CNT_W  saturating match count (only with the optional feature).

Behaviour:
- Reset (rstn low, async): all outputs 0; state IDLE; internal pattern/len/overlap = 0; history and fill count cleared.
- FSM states:
  - IDLE: no config loaded. Ignores in_valid; out stays 0.
  - FILL: fill < len.
  - DETECT: fill >= len.
- Config load (cfg_load high):
  - Latch pattern/len/overlap; clear history and fill.
  - Next state FILL if 1 <= cfg_len <= PAT_W; otherwise IDLE and set cfg_err.
  - cfg_err clears only on reset.
  - cfg_load has priority over in_valid in the same cycle; that input bit is discarded.
- Sampling (in_valid high, not IDLE, no cfg_load):
  - hist <= {hist[PAT_W-2:0], in}.
  - fill <= min(fill+1, PAT_W).
- Match condition: (next hist)[len-1:0] == pattern[len-1:0] AND next fill >= len.
  - out is registered: high for exactly one cycle following the sampling edge of the completing bit.
  - Latency is 1 clock from that bit's sample edge.
- Overlap mode: history and fill are retained after a match; the FSM stays in DETECT.
- Non-overlap mode: on a match, fill <= 0 and state -> FILL; no bit of a matched sequence contributes to a later match.
- in_valid low: history, fill and state hold; out = 0.
- len == 1: every sampled bit equal to pattern[0] produces a match.
- Upper pattern bits above len are ignored.
- Reset mid-sequence discards partial history; a new cfg_load is required.
- armed = (state != IDLE).

Optional Feature:
- Macro SEQ_DET_MATCH_CNT_EN.
- Defined:
  - match_cnt increments on each out pulse and saturates at 2^CNT_W-1.
  - cnt_clr clears it to 0.
  - cnt_clr together with a match in the same cycle yields 1.
- Undefined: match_cnt is tied to 0; cnt_clr is ignored; no counter flops are synthesised.

Decomposition:
- Package seq_detector_pkg:
  - state enum type (IDLE, FILL, DETECT).
  - localparam default PAT_W / CNT_W.
  - function computing the masked compare (hist, pattern, len) -> match.
- One natural sub-module: seq_match_counter, the saturating counter with clear, instantiated under SEQ_DET_MATCH_CNT_EN.

Test Plan:
- Pattern 4'b1011, len 4, overlap 1; stream 1,0,1,1,0,0,1,1,0,1,1 -> out pulses after bits 4 and 11; match_cnt = 2.
- Pattern 4'b1011, len 4; stream 1,0,1,1,0,1,1:
  - overlap 1 -> pulses after bits 4 and 7.
  - overlap 0 -> pulse after bit 4 only.
- Pattern 3'b111, len 3; six 1s:
  - overlap 1 -> 4 pulses (bits 3-6).
  - overlap 0 -> 2 pulses (bits 3, 6).
- Pattern 1011 with in_valid deasserted for 3 cycles between bits 2 and 3 -> single pulse after the 4th valid bit; no pulse while in_valid is low.
- cfg_load with cfg_len=0 -> cfg_err=1, armed=0, no pulses on any stream; a subsequent legal load -> armed=1, cfg_err stays 1.
- CNT_W=2: 5 matches -> match_cnt saturates at 3; cnt_clr coincident with a match -> match_cnt=1; rstn pulse mid-pattern -> all outputs 0, armed=0.
